// File: rtl/mapu_nxn_pkg.sv
// mapu_nxn_pkg: operation/state encodings and element-range helpers for the N x N matrix unit.
package mapu_nxn_pkg;

    typedef enum logic [1:0] {
        OP_ADD       = 2'b00,
        OP_SUB       = 2'b01,
        OP_MULT      = 2'b10,
        OP_TRANSPOSE = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_COMPUTE,
        ST_OUTPUT
    } state_e;

    function automatic int acc_width(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

    function automatic logic signed [63:0] elem_max(input int dw);
        return (64'sd1 <<< (dw - 1)) - 64'sd1;
    endfunction

    function automatic logic is_of(input logic signed [63:0] v, input int dw);
        return (v > elem_max(dw)) || (v < -elem_max(dw) - 64'sd1);
    endfunction

    function automatic logic signed [63:0] clamp(input logic signed [63:0] v, input int dw);
        if (v > elem_max(dw))
            return elem_max(dw);
        else if (v < -elem_max(dw) - 64'sd1)
            return -elem_max(dw) - 64'sd1;
        else
            return v;
    endfunction

endpackage

// File: rtl/mapu_nxn_dot.sv
// mapu_nxn_dot: full-precision signed dot product of one row of A with one column of B.
module mapu_nxn_dot
    import mapu_nxn_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 3
) (
    input  logic [N*DATA_WIDTH-1:0]                   a,
    input  logic [N*DATA_WIDTH-1:0]                   b,
    output logic signed [acc_width(DATA_WIDTH, N)-1:0] dot
);
    localparam int ACC_W = acc_width(DATA_WIDTH, N);

    logic signed [2*DATA_WIDTH-1:0] pa, pb, prod;

    // Operands are widened first so the product is evaluated at full width.
    always_comb begin
        dot  = '0;
        pa   = '0;
        pb   = '0;
        prod = '0;
        for (int k = 0; k < N; k++) begin
            pa   = (2*DATA_WIDTH)'(signed'(a[k*DATA_WIDTH +: DATA_WIDTH]));
            pb   = (2*DATA_WIDTH)'(signed'(b[k*DATA_WIDTH +: DATA_WIDTH]));
            prod = pa * pb;
            dot  = dot + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/mapu_nxn.sv
// mapu_nxn: N x N signed matrix ADD/SUB/MULT/TRANSPOSE unit with valid/ready in and out.
// Define MAPU_NXN_SATURATE_EN to clamp overflowing elements instead of wrapping.
//
// state      | meaning
// IDLE       | block disabled, nothing pending
// LOAD_A     | waiting for operand A and the operation
// LOAD_B     | waiting for operand B (not visited for TRANSPOSE)
// COMPUTE    | result built into staging, one row per cycle for MULT
// OUTPUT     | result presented until accepted
module mapu_nxn
    import mapu_nxn_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_en,
    input  logic [1:0]                i_op,
    input  logic                      i_vld,
    output logic                      o_rdy,
    input  logic [N*N*DATA_WIDTH-1:0] i_mat,
    output logic                      o_vld,
    input  logic                      i_rdy,
    output logic [N*N*DATA_WIDTH-1:0] o_mat,
    output logic                      o_of
);
    localparam int EW    = DATA_WIDTH;
    localparam int MW    = N * N * DATA_WIDTH;
    localparam int ACC_W = acc_width(DATA_WIDTH, N);
    localparam int CW    = $clog2(N + 1);

    state_e                  state, state_nx;
    op_e                     op_q;
    logic [MW-1:0]           a_q, b_q, stage_q, comp_mat;
    logic                    stage_of_q, comp_of, elem_of;
    logic [CW-1:0]           cnt_q, last_cnt;
    logic [N*EW-1:0]         a_row;
    logic [N*ACC_W-1:0]      dots;
    logic signed [EW-1:0]    ea, eb;
    logic signed [63:0]      full;

    // One extra COMPUTE cycle after the last staging write moves staging to the output.
    assign last_cnt = (op_q == OP_MULT) ? CW'(N) : CW'(1);

    always_comb begin
        a_row = '0;
        for (int k = 0; k < N; k++)
            if (int'(cnt_q) < N)
                a_row[k*EW +: EW] = a_q[(int'(cnt_q)*N + k)*EW +: EW];
    end

    for (genvar c = 0; c < N; c++) begin : g_dot
        logic [N*EW-1:0] b_col;
        for (genvar k = 0; k < N; k++) begin : g_col
            assign b_col[k*EW +: EW] = b_q[(k*N + c)*EW +: EW];
        end
        mapu_nxn_dot #(.DATA_WIDTH(DATA_WIDTH), .N(N)) u_dot (
            .a   (a_row),
            .b   (b_col),
            .dot (dots[c*ACC_W +: ACC_W])
        );
    end

    always_comb begin
        comp_mat = stage_q;
        comp_of  = (op_q == OP_MULT) ? stage_of_q : 1'b0;
        ea       = '0;
        eb       = '0;
        full     = '0;
        elem_of  = 1'b0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                ea = a_q[(r*N + c)*EW +: EW];
                eb = b_q[(r*N + c)*EW +: EW];
                case (op_q)
                    OP_ADD:  full = 64'(ea) + 64'(eb);
                    OP_SUB:  full = 64'(ea) - 64'(eb);
                    OP_MULT: full = 64'(signed'(dots[c*ACC_W +: ACC_W]));
                    default: full = 64'(signed'(a_q[(c*N + r)*EW +: EW]));
                endcase
                elem_of = is_of(full, EW);
                if (op_q != OP_MULT || r == int'(cnt_q)) begin
`ifdef MAPU_NXN_SATURATE_EN
                    comp_mat[(r*N + c)*EW +: EW] = EW'(clamp(full, EW));
`else
                    comp_mat[(r*N + c)*EW +: EW] = EW'(full);
`endif
                    comp_of = comp_of | elem_of;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        o_rdy    = i_en && (state == ST_LOAD_A || state == ST_LOAD_B);
        o_vld    = (state == ST_OUTPUT);
        if (!i_en) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    state_nx = ST_LOAD_A;
                ST_LOAD_A:  if (i_vld) state_nx = (op_e'(i_op) == OP_TRANSPOSE) ? ST_COMPUTE : ST_LOAD_B;
                ST_LOAD_B:  if (i_vld) state_nx = ST_COMPUTE;
                ST_COMPUTE: if (cnt_q == last_cnt) state_nx = ST_OUTPUT;
                ST_OUTPUT:  if (i_rdy) state_nx = ST_LOAD_A;
                default:    state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q       <= OP_ADD;
            a_q        <= '0;
            b_q        <= '0;
            stage_q    <= '0;
            stage_of_q <= 1'b0;
            cnt_q      <= '0;
            o_mat      <= '0;
            o_of       <= 1'b0;
        end else if (!i_en) begin
            stage_of_q <= 1'b0;
            cnt_q      <= '0;
            o_mat      <= '0;
            o_of       <= 1'b0;
        end else begin
            case (state)
                ST_LOAD_A: if (i_vld) begin
                    a_q        <= i_mat;
                    op_q       <= op_e'(i_op);
                    cnt_q      <= '0;
                    stage_of_q <= 1'b0;
                end
                ST_LOAD_B: if (i_vld) b_q <= i_mat;
                ST_COMPUTE: begin
                    if (cnt_q != last_cnt) begin
                        stage_q    <= comp_mat;
                        stage_of_q <= comp_of;
                        cnt_q      <= cnt_q + 1'b1;
                    end else begin
                        o_mat <= stage_q;
                        o_of  <= stage_of_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mapu_nxn.sv
// tb_mapu_nxn: directed vector table plus hand sequences for backpressure, abort and reset.
module tb_mapu_nxn;
    typedef logic [71:0] mat_t;

    typedef struct {
        string      name;
        logic [1:0] op;
        mat_t       a;
        mat_t       b;
        mat_t       exp;
        logic       exp_of;
        int         lat;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_en = 1'b0;
    logic [1:0] i_op = 2'b00;
    logic       i_vld = 1'b0;
    logic       o_rdy;
    mat_t       i_mat = '0;
    logic       o_vld;
    logic       i_rdy = 1'b0;
    mat_t       o_mat;
    logic       o_of;

    int n_vec  = 0;
    int n_miss = 0;
    vec_t vecs[$];

    mapu_nxn #(.DATA_WIDTH(8), .N(3)) dut (
        .clk   (clk),
        .reset (reset),
        .i_en  (i_en),
        .i_op  (i_op),
        .i_vld (i_vld),
        .o_rdy (o_rdy),
        .i_mat (i_mat),
        .o_vld (o_vld),
        .i_rdy (i_rdy),
        .o_mat (o_mat),
        .o_of  (o_of)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic mat_t pack9(input int e0, input int e1, input int e2,
                                   input int e3, input int e4, input int e5,
                                   input int e6, input int e7, input int e8);
        mat_t m;
        int   e[9];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
        e[5] = e5; e[6] = e6; e[7] = e7; e[8] = e8;
        for (int i = 0; i < 9; i++) m[i*8 +: 8] = 8'(e[i]);
        return m;
    endfunction

    function automatic mat_t all9(input int v);
        return pack9(v, v, v, v, v, v, v, v, v);
    endfunction

    function automatic vec_t mkv(input string nm, input logic [1:0] op, input mat_t a,
                                 input mat_t b, input mat_t exp, input logic of, input int lat);
        vec_t v;
        v.name = nm; v.op = op; v.a = a; v.b = b; v.exp = exp; v.exp_of = of; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string nm, input mat_t act, input mat_t exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input mat_t m, output bit ok);
        int n = 0;
        @(negedge clk);
        while (!o_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = o_rdy;
        if (!ok) return;
        i_vld = 1'b1;
        i_op  = op;
        i_mat = m;
        @(posedge clk);
        #1;
        i_vld = 1'b0;
        i_mat = '0;
    endtask

    task automatic out_xfer(input string nm);
        @(negedge clk);
        i_rdy = 1'b1;
        @(posedge clk);
        #1;
        i_rdy = 1'b0;
        chk({nm, "/vld_after"}, 72'(o_vld), 72'(0));
        chk({nm, "/rdy_after"}, 72'(o_rdy), 72'(1));
    endtask

    // Applies one operation; leaves o_vld held when release is 0.
    task automatic do_op(input vec_t v, input bit release_out);
        bit ok;
        bit rdy_seen;
        int lat;
        send(v.op, v.a, ok);
        chk({v.name, "/acceptA"}, 72'(ok), 72'(1));
        if (v.op != 2'b11) begin
            send(v.op ^ 2'b01, v.b, ok);
            chk({v.name, "/acceptB"}, 72'(ok), 72'(1));
        end
        rdy_seen = o_rdy;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (o_rdy) rdy_seen = 1'b1;
            if (o_vld) break;
        end
        chk({v.name, "/latency"}, 72'(lat), 72'(v.lat));
        chk({v.name, "/rdy_busy"}, 72'(rdy_seen), 72'(0));
        chk({v.name, "/mat"}, o_mat, v.exp);
        chk({v.name, "/of"}, 72'(o_of), 72'(v.exp_of));
        if (release_out) out_xfer(v.name);
    endtask

    initial begin
        mat_t seq, ident;
        bit   ok, bad;
        seq   = pack9(1, 2, 3, 4, 5, 6, 7, 8, 9);
        ident = pack9(1, 0, 0, 0, 1, 0, 0, 0, 1);

        vecs.push_back(mkv("add_10_20",   2'b00, all9(10),   all9(20),  all9(30),  1'b0, 2));
        vecs.push_back(mkv("sub_wrap",    2'b01, all9(-100), all9(100), all9(56),  1'b1, 2));
        vecs.push_back(mkv("mult_ident",  2'b10, ident,      seq,       seq,       1'b0, 4));
        vecs.push_back(mkv("mult_10",     2'b10, all9(10),   all9(10),  all9(44),  1'b1, 4));
        vecs.push_back(mkv("transpose",   2'b11, seq,        '0,
                           pack9(1, 4, 7, 2, 5, 8, 3, 6, 9), 1'b0, 2));
        vecs.push_back(mkv("add_cancel",  2'b00, seq, pack9(-1, -2, -3, -4, -5, -6, -7, -8, -9),
                           all9(0), 1'b0, 2));
        vecs.push_back(mkv("add_max",     2'b00, all9(100),  all9(27),  all9(127), 1'b0, 2));
        vecs.push_back(mkv("add_over",    2'b00, all9(127),  all9(1),   all9(-128), 1'b1, 2));
        vecs.push_back(mkv("sub_min",     2'b01, all9(-28),  all9(100), all9(-128), 1'b0, 2));
        vecs.push_back(mkv("mult_seq",    2'b10, seq, seq,
                           pack9(30, 36, 42, 66, 81, 96, 102, 126, -106), 1'b1, 4));
        vecs.push_back(mkv("mult_min",    2'b10, all9(-128), all9(-128), all9(0),  1'b1, 4));
        vecs.push_back(mkv("add_last_of", 2'b00, pack9(0, 0, 0, 0, 0, 0, 0, 0, 127),
                           pack9(0, 0, 0, 0, 0, 0, 0, 0, 1),
                           pack9(0, 0, 0, 0, 0, 0, 0, 0, -128), 1'b1, 2));

        // Reset state and disabled block
        repeat (2) @(posedge clk);
        #1;
        chk("reset/rdy", 72'(o_rdy), 72'(0));
        chk("reset/vld", 72'(o_vld), 72'(0));
        chk("reset/mat", o_mat, '0);
        chk("reset/of",  72'(o_of), 72'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("disabled/rdy", 72'(o_rdy), 72'(0));
        @(negedge clk);
        i_en = 1'b1;

        foreach (vecs[i]) do_op(vecs[i], 1'b1);

        // Backpressure: result must hold while i_rdy is low
        do_op(vecs[1], 1'b0);
        bad = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (o_mat !== vecs[1].exp || o_of !== 1'b1 || o_vld !== 1'b1 || o_rdy !== 1'b0)
                bad = 1'b1;
        end
        chk("bp/stable", 72'(bad), 72'(0));
        out_xfer("bp");
        @(posedge clk);
        #1;
        chk("bp/single_xfer", 72'(o_vld), 72'(0));

        // Abort during MULT compute
        send(2'b10, seq, ok);
        send(2'b11, seq, ok);
        chk("abort/loaded", 72'(ok), 72'(1));
        @(posedge clk);
        #1;
        @(negedge clk);
        i_en = 1'b0;
        @(posedge clk);
        #1;
        chk("abort/vld", 72'(o_vld), 72'(0));
        chk("abort/rdy", 72'(o_rdy), 72'(0));
        chk("abort/of",  72'(o_of), 72'(0));
        bad = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (o_vld || o_rdy) bad = 1'b1;
        end
        chk("abort/quiet", 72'(bad), 72'(0));
        @(negedge clk);
        i_en = 1'b1;
        do_op(vecs[0], 1'b1);

        // Asynchronous reset while a result is pending
        do_op(vecs[3], 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid/vld", 72'(o_vld), 72'(0));
        chk("rst_mid/mat", o_mat, '0);
        chk("rst_mid/of",  72'(o_of), 72'(0));
        @(negedge clk);
        reset = 1'b0;
        do_op(vecs[9], 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mapu_nxn.md
Name: mapu_nxn

Overview:
- Parametrised successor to the fixed 3x3 Matrix APU.
- Accepts N x N signed matrices of configurable element width over a valid/ready input handshake and computes ADD, SUB, MULT or TRANSPOSE.
- Returns the result matrix with an overflow flag over a valid/ready output handshake.
- Sits behind the block agent interface in the mapu block testbench, replacing mapu_top in next-generation configurations.

Parameters:
- DATA_WIDTH, 8, signed element width in bits (min 4)
- N, 3, matrix dimension (rows = columns), 2..8

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- i_en  in  1  block enable; low forces idle/abort
- i_op  in  2  operation: 00 ADD, 01 SUB, 10 MULT, 11 TRANSPOSE
- i_vld  in  1  input matrix valid
- o_rdy  out  1  input ready
- i_mat  in  N*N*DATA_WIDTH  input matrix, row-major, element [r][c] at bits (r*N+c)*DATA_WIDTH
- o_vld  out  1  result valid
- i_rdy  in  1  result ready
- o_mat  out  N*N*DATA_WIDTH  result matrix, same packing
- o_of  out  1  overflow: any result element outside signed DATA_WIDTH range; valid with o_vld

Behaviour:
- Reset: FSM=IDLE, o_rdy=0, o_vld=0, o_mat=0, o_of=0, operand/accumulator registers cleared.
- Input transfer on i_vld&&o_rdy; output transfer on o_vld&&i_rdy.
- o_rdy=1 only in LOAD_A or LOAD_B with i_en=1.
- FSM states: IDLE, LOAD_A, LOAD_B, COMPUTE, OUTPUT.
  - IDLE -> LOAD_A when i_en=1.
  - LOAD_A: on transfer, latch A and i_op. -> COMPUTE if op=TRANSPOSE, else -> LOAD_B.
  - LOAD_B: on transfer, latch B. -> COMPUTE. i_op ignored in this state.
  - COMPUTE:
    - ADD/SUB/TRANSPOSE: 1 cycle.
    - MULT: N cycles; row r computed in cycle r using N*N multipliers and an accumulator of width 2*DATA_WIDTH+$clog2(N).
    - -> OUTPUT after the last cycle, with o_mat/o_of registered.
  - OUTPUT: o_vld=1; o_mat/o_of held stable until transfer. On transfer -> LOAD_A if i_en=1, else IDLE.
- Latency, operand transfer at edge t to o_vld high:
  - ADD/SUB/TRANSPOSE: o_vld at t+2
  - MULT: o_vld at t+N+1
- Arithmetic: full-precision signed intermediates; result truncated to the low DATA_WIDTH bits (wrap); o_of = OR of per-element overflow. TRANSPOSE: o_of=0.
- i_en=0 in any non-IDLE state: next edge -> IDLE; o_vld, o_rdy drop; pending operands/result discarded; o_of cleared.
- Back-to-back: a new A may be accepted on the cycle after an output transfer, never in the same cycle. No overlap of compute with loading.
- Asynchronous reset mid-operation: immediate return to reset values; no partial output.
- Unused i_op encodings: none (all 4 defined).

Optional Feature:
- MAPU_NXN_SATURATE_EN.
- Defined: overflowing elements clamp to +(2^(DATA_WIDTH-1)-1) or -2^(DATA_WIDTH-1); o_of still asserted.
- Undefined: wrap-around truncation as above.

Decomposition:
- Package mapu_nxn_pkg:
  - op enum (ADD/SUB/MULT/TRANSPOSE)
  - FSM state enum
  - function computing the accumulator width
  - saturate/overflow-check function
- Sub-module mapu_nxn_dot: one N-element signed dot-product row unit (N multipliers + adder tree), instantiated N times for MULT row computation.

Test Plan (N=3, DATA_WIDTH=8):
- ADD A=all 10, B=all 20 -> o_mat all 30, o_of=0, o_vld 2 cycles after B transfer.
- SUB A=all -100, B=all 100 -> all elements 56 (wrap), o_of=1. With MAPU_NXN_SATURATE_EN: all -128, o_of=1.
- MULT A=identity, B=[[1,2,3],[4,5,6],[7,8,9]] -> o_mat=B, o_of=0, o_vld 4 cycles after B transfer. Then A=B=all 10 -> elements 300 wrap to 44, o_of=1.
- TRANSPOSE A=[[1,2,3],[4,5,6],[7,8,9]] -> [[1,4,7],[2,5,8],[3,6,9]]; o_rdy never high for a second operand.
- Backpressure: hold i_rdy=0 for 5 cycles with o_vld=1 -> o_mat/o_of stable, o_rdy=0 throughout; release -> single transfer, o_rdy high next cycle.
- Abort/reset: drop i_en during MULT COMPUTE -> no o_vld, IDLE next cycle. Assert reset while o_vld=1 -> o_vld, o_mat, o_of return to 0 immediately.
